bidir_shift_engine: RTL and testbench

Parametrised bidirectional shift engine that generalises the team's 4-bit PISO/bidirectional register to WIDTH bits. A parallel word is loaded through a valid/ready handshake, shifted out MSB-first or LSB-first, and an incoming serial bit is captured on every shift. After WIDTH shifts the received word is presented with a one-cycle valid strobe. The block sits between parallel datapath logic and bit-serial links such as SPI-style lanes and inter-board serial pins.

---
 rtl/shift_pkg.sv | 21 ++
 rtl/universal_shift_core.sv | 28 ++
 rtl/bidir_shift_engine.sv | 103 ++++++++++
 tb/tb_bidir_shift_engine.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the bidirectional shift engine.
// The engine FSM states and the shift core mode encoding live here.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_HOLD,
    MODE_LOAD,
    MODE_LEFT,
    MODE_RIGHT
  } mode_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/universal_shift_core.sv
// WIDTH-bit universal shift register: hold, parallel load, shift left or shift right.
// A serial bit enters at the vacated end on every shift.
module universal_shift_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);
  import shift_pkg::*;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      case (mode_t'(mode))
        MODE_LOAD:  q <= par_in;
        MODE_LEFT:  q <= {q[WIDTH-2:0], ser_in};
        MODE_RIGHT: q <= {ser_in, q[WIDTH-1:1]};
        default:    q <= q;
      endcase
    end
  end

endmodule

// File: rtl/bidir_shift_engine.sv
// Bidirectional parallel/serial shift engine: accepts a word over valid/ready,
// shifts it out MSB- or LSB-first while capturing ser_in, then strobes the received word.
module bidir_shift_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_dir,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             busy,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);
  import shift_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dir;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  mode_t            mode;
  logic             accept;
  logic             step;

  universal_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .par_in (load_data),
    .ser_in (ser_in),
    .q      (shift_reg)
  );

  // Handshake and datapath steering; outputs decode directly from registered state.
  always_comb begin
    load_ready = !rst && (state != SHIFT);
    accept     = load_valid && load_ready;
    step       = (state == SHIFT) && shift_en;
    busy       = (state == SHIFT);
    rx_valid   = (state == DONE);
    ser_out    = 1'b0;
    if (state == SHIFT) begin
      ser_out = (dir == DIR_LEFT) ? shift_reg[WIDTH-1] : shift_reg[0];
    end
    mode = MODE_HOLD;
    if (accept) begin
      mode = MODE_LOAD;
    end else if (step) begin
      mode = (dir == DIR_LEFT) ? MODE_LEFT : MODE_RIGHT;
    end
    // The value the core takes on this edge, so rx_data is ready in the DONE cycle.
    shifted = (dir == DIR_LEFT) ? {shift_reg[WIDTH-2:0], ser_in}
                                : {ser_in, shift_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      dir     <= DIR_RIGHT;
      rx_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dir   <= load_dir;
            cnt   <= CNT_W'(WIDTH);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              rx_data <= shifted;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          if (accept) begin
            dir   <= load_dir;
            cnt   <= CNT_W'(WIDTH);
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bidir_shift_engine.sv
// Scoreboard bench for bidir_shift_engine (WIDTH = 8): stimulus pushes expected
// serial bits and received words, a negedge monitor pops and compares them.
module tb_bidir_shift_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_data;
  logic       load_dir;
  logic       shift_en;
  logic       ser_in;
  logic       ser_out;
  logic       busy;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic       loop_en;
  logic       ext_bit;

  typedef struct {
    logic [7:0] data;
    int         lat;
  } rx_exp_t;

  logic    bit_q[$];
  rx_exp_t rx_q[$];
  int      acc_q[$];

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  assign ser_in = loop_en ? ser_out : ext_bit;

  bidir_shift_engine #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dir   (load_dir),
    .shift_en   (shift_en),
    .ser_in     (ser_in),
    .ser_out    (ser_out),
    .busy       (busy),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic fail_check(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got event, expected none", name);
  endtask

  // Monitor: compares every consumed serial bit and every rx_valid strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && shift_en) begin
        if (bit_q.size() == 0) fail_check("unexpected_shift");
        else check_output("ser_out_bit", 32'(ser_out), 32'(bit_q.pop_front()));
      end
      if (rx_valid) begin
        if (rx_q.size() == 0 || acc_q.size() == 0) begin
          fail_check("unexpected_rx_valid");
        end else begin
          rx_exp_t e;
          int      a;
          e = rx_q.pop_front();
          a = acc_q.pop_front();
          check_output("rx_data", 32'(rx_data), 32'(e.data));
          check_output("rx_latency", 32'(cycle - a), 32'(e.lat));
          check_output("busy_in_done", 32'(busy), 32'(0));
        end
      end
      if (load_valid) begin
        check_output("load_ready", 32'(load_ready), 32'(!busy));
        if (load_ready) acc_q.push_back(cycle);
      end
    end
  end

  // Present a word, push its expected bits and result, hold until accepted.
  task automatic apply_stimulus(input logic [7:0] word, input logic dir,
                                input logic [7:0] exp_rx, input int exp_lat,
                                output logic in_done);
    rx_exp_t e;
    logic    acc;
    load_data  = word;
    load_dir   = dir;
    load_valid = 1'b1;
    for (int i = 0; i < 8; i++) bit_q.push_back(dir ? word[7-i] : word[i]);
    e.data = exp_rx;
    e.lat  = exp_lat;
    rx_q.push_back(e);
    acc     = 1'b0;
    in_done = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      if (load_ready) begin
        acc     = 1'b1;
        in_done = rx_valid;
      end
    end
    if (!acc) fail_check("accept_timeout");
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bit_q.size() != 0 || rx_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) fail_check("drain_timeout");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic d;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_dir   = 1'b0;
    shift_en   = 1'b1;
    loop_en    = 1'b1;
    ext_bit    = 1'b0;

    #3;
    check_output("rst_busy", 32'(busy), 32'(0));
    check_output("rst_ser_out", 32'(ser_out), 32'(0));
    check_output("rst_rx_data", 32'(rx_data), 32'(0));
    check_output("rst_rx_valid", 32'(rx_valid), 32'(0));
    check_output("rst_load_ready", 32'(load_ready), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("ready_after_rst", 32'(load_ready), 32'(1));
    @(posedge clk);
    #1;

    // Loopback MSB-first
    apply_stimulus(8'h96, 1'b1, 8'h96, 9, d);
    drain();

    // LSB-first with ser_in tied high
    loop_en = 1'b0;
    ext_bit = 1'b1;
    apply_stimulus(8'h96, 1'b0, 8'hFF, 9, d);
    drain();

    // Gated loopback: stall three cycles after three shifts, ser_out must hold
    loop_en = 1'b1;
    apply_stimulus(8'h96, 1'b1, 8'h96, 12, d);
    repeat (3) @(posedge clk);
    #1 shift_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_output("gated_hold", 32'(ser_out), 32'(1));
      check_output("gated_busy", 32'(busy), 32'(1));
      @(posedge clk);
    end
    #1 shift_en = 1'b1;
    drain();

    // Back-to-back: second word accepted in the DONE cycle
    apply_stimulus(8'h96, 1'b1, 8'h96, 9, d);
    apply_stimulus(8'h0F, 1'b1, 8'h0F, 9, d);
    check_output("b2b_accept_in_done", 32'(d), 32'(1));
    drain();

    // Busy ignore, then reset mid-transaction
    apply_stimulus(8'h96, 1'b1, 8'h96, 9, d);
    load_data  = 8'h55;
    load_dir   = 1'b0;
    load_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    load_valid = 1'b0;
    rst        = 1'b1;
    #1;
    check_output("abort_busy", 32'(busy), 32'(0));
    check_output("abort_ser_out", 32'(ser_out), 32'(0));
    check_output("abort_rx_data", 32'(rx_data), 32'(0));
    check_output("abort_rx_valid", 32'(rx_valid), 32'(0));
    bit_q.delete();
    rx_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("ready_after_abort", 32'(load_ready), 32'(1));
    @(posedge clk);
    #1;
    apply_stimulus(8'hA5, 1'b0, 8'hA5, 9, d);
    drain();
    check_output("final_rx_data", 32'(rx_data), 32'(8'hA5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
